// File: rtl/psum_accumulator.sv
// Partial-sum accumulator: folds successive K-tiles of column psums into a row buffer
// with signed saturation, then drains finished rows over a valid/ready handshake.
module psum_accumulator #(
   parameter int ACC_WIDTH = 32,
   parameter int COLS      = 4,
   parameter int DEPTH     = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [COLS*ACC_WIDTH-1:0] in_psum,
   input  logic                      tile_first,
   input  logic                      tile_last,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [COLS*ACC_WIDTH-1:0] out_data,
   output logic [$clog2(DEPTH)-1:0]  out_row,
   output logic                      sat_flag
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int ROW_W = COLS * ACC_WIDTH;
   localparam logic [PTR_W-1:0] LAST_ROW = PTR_W'(DEPTH - 1);

   typedef enum logic {ACCUM, DRAIN} state_t;

   state_t           state_reg, state_next;
   logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
   logic             cur_first_reg, cur_last_reg;
   logic             out_valid_reg, sat_flag_reg;
   logic [ROW_W-1:0] out_data_reg;
   logic [ROW_W-1:0] row_mem [DEPTH];

   logic             beat, eff_first, eff_last;
   logic             tile_done, row_taken, drain_done;
   logic [ROW_W-1:0] acc_row, wr_row;
   logic [COLS-1:0]  lane_sat;
   logic             beat_sat;

   // Accept qualification uses the state directly so it does not loop through in_ready.
   assign beat       = in_valid && (state_reg == ACCUM);
   assign eff_first  = (wr_ptr_reg == '0) ? tile_first : cur_first_reg;
   assign eff_last   = (wr_ptr_reg == '0) ? tile_last  : cur_last_reg;
   assign tile_done  = beat && (wr_ptr_reg == LAST_ROW) && eff_last;
   assign row_taken  = out_valid_reg && out_ready;
   assign drain_done = row_taken && (rd_ptr_reg == LAST_ROW);
   assign acc_row    = row_mem[wr_ptr_reg];
   assign beat_sat   = |lane_sat;

   for (genvar gi = 0; gi < COLS; gi++) begin : g_lane
      logic signed [ACC_WIDTH-1:0] old_v, new_v, clamp_v;
      logic        [ACC_WIDTH:0]   sum_v;
      logic                        ovf;

      assign old_v = acc_row[gi*ACC_WIDTH +: ACC_WIDTH];
      assign new_v = in_psum[gi*ACC_WIDTH +: ACC_WIDTH];
      assign sum_v = {old_v[ACC_WIDTH-1], old_v} + {new_v[ACC_WIDTH-1], new_v};
      // Sign bit and guard bit disagree only when the true sum left the ACC_WIDTH range.
      assign ovf   = sum_v[ACC_WIDTH] != sum_v[ACC_WIDTH-1];

      always_comb begin
         clamp_v = sum_v[ACC_WIDTH-1:0];
         if (ovf) begin
            clamp_v = sum_v[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                       : {1'b0, {(ACC_WIDTH-1){1'b1}}};
         end
      end

      assign wr_row[gi*ACC_WIDTH +: ACC_WIDTH] = eff_first ? new_v : clamp_v;
      assign lane_sat[gi] = ovf && !eff_first;
   end

   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      case (state_reg)
         ACCUM: begin
            in_ready = 1'b1;
            if (tile_done) state_next = DRAIN;
         end
         DRAIN: begin
            if (drain_done) state_next = ACCUM;
         end
         default: state_next = ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ACCUM;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         cur_first_reg <= 1'b0;
         cur_last_reg  <= 1'b0;
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         sat_flag_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (beat) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (wr_ptr_reg == '0) begin
               cur_first_reg <= tile_first;
               cur_last_reg  <= tile_last;
            end
            if (tile_done) sat_flag_reg <= beat_sat;
            else           sat_flag_reg <= sat_flag_reg | beat_sat;
         end
         // Row 0 was written DEPTH-1 beats ago, so it can be fetched on the final beat.
         if (tile_done) begin
            rd_ptr_reg    <= '0;
            out_valid_reg <= 1'b1;
            out_data_reg  <= row_mem[0];
         end else if (row_taken) begin
            rd_ptr_reg   <= rd_ptr_reg + 1'b1;
            out_data_reg <= row_mem[rd_ptr_reg + 1'b1];
            if (rd_ptr_reg == LAST_ROW) out_valid_reg <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (beat) row_mem[wr_ptr_reg] <= wr_row;
   end

   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign out_row   = rd_ptr_reg;
   assign sat_flag  = sat_flag_reg;
endmodule

// File: tb/tb_psum_accumulator.sv
// Directed scoreboard bench for psum_accumulator: stimulus queues expected rows,
// a forked monitor pops and compares each row the DUT hands over.
module tb_psum_accumulator;
   localparam int AW    = 32;
   localparam int COLS  = 4;
   localparam int DEPTH = 8;
   localparam int RW    = AW * COLS;

   logic          clk = 1'b0;
   logic          rst, in_valid, in_ready, tile_first, tile_last;
   logic          out_valid, out_ready, sat_flag;
   logic [RW-1:0] in_psum, out_data;
   logic [2:0]    out_row;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [RW-1:0] data;
      logic [2:0]    row;
   } exp_t;

   exp_t          exp_q[$];
   logic [RW-1:0] tile_rows [DEPTH];
   logic [RW-1:0] exp_rows  [DEPTH];

   always #5 clk = ~clk;

   psum_accumulator #(.ACC_WIDTH(AW), .COLS(COLS), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_psum(in_psum), .tile_first(tile_first), .tile_last(tile_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_row(out_row), .sat_flag(sat_flag)
   );

   function automatic logic [RW-1:0] pack4(input logic [31:0] l0, input logic [31:0] l1,
                                           input logic [31:0] l2, input logic [31:0] l3);
      return {l3, l2, l1, l0};
   endfunction

   task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_ramp();
      for (int r = 0; r < DEPTH; r++) begin
         tile_rows[r] = pack4(32'(10*r), 32'(10*r+1), 32'(10*r+2), 32'(10*r+3));
         exp_rows[r]  = tile_rows[r];
      end
   endtask

   task automatic push_expected();
      for (int r = 0; r < DEPTH; r++) exp_q.push_back({exp_rows[r], 3'(r)});
   endtask

   // Later beats drive inverted first/last to prove only beat 0 is sampled.
   task automatic send_tile(input logic first, input logic last, input bit stall);
      for (int r = 0; r < DEPTH; r++) begin
         if (stall) begin
            in_valid   = 1'b0;
            in_psum    = {4{32'hDEADBEEF}};
            tile_first = ~first;
            tile_last  = ~last;
            tick();
         end
         in_valid   = 1'b1;
         in_psum    = tile_rows[r];
         tile_first = (r == 0) ? first : ~first;
         tile_last  = (r == 0) ? last : ~last;
         check("in_ready_beat", in_ready, 1);
         check("out_valid_accum", out_valid, 0);
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic check_drain_start();
      check("out_valid_rise", out_valid, 1);
      check("in_ready_drain", in_ready, 0);
      check("first_row_index", out_row, 0);
   endtask

   task automatic wait_row(input int n);
      int k;
      for (k = 0; k < 40 && !(out_valid && out_row == 3'(n)); k++) tick();
      check("reach_row", {out_valid, out_row}, {1'b1, 3'(n)});
   endtask

   task automatic wait_drain_done();
      int k;
      for (k = 0; k < 40 && out_valid; k++) tick();
      check("drain_ends", out_valid, 0);
      check("in_ready_after_drain", in_ready, 1);
      check("rows_all_seen", exp_q.size(), 0);
   endtask

   task automatic fill_sat_tile(input int which);
      for (int r = 0; r < DEPTH; r++) begin
         if (which == 1) tile_rows[r] = pack4(32'h7FFFFFF0, 32'h80000010, 32'd100, 32'd1);
         else            tile_rows[r] = pack4(32'h00000020, 32'hFFFFFFE0, 32'hFFFFFFE2, 32'd2);
         exp_rows[r] = pack4(32'h7FFFFFFF, 32'h80000000, 32'd70, 32'd3);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      exp_t e;
      rst = 1'b1; in_valid = 1'b0; in_psum = '0;
      tile_first = 1'b0; tile_last = 1'b0; out_ready = 1'b1;

      fork
         forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_row: got row %0d data %h, required no row", out_row, out_data);
               end else begin
                  e = exp_q.pop_front();
                  check("row_index", out_row, e.row);
                  check("row_data", out_data, e.data);
               end
            end
         end
      join_none

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_row", out_row, 0);
      check("rst_sat_flag", sat_flag, 0);

      // Single tile, rows drained unchanged.
      fill_ramp();
      push_expected();
      send_tile(1'b1, 1'b1, 1'b0);
      check_drain_start();
      wait_drain_done();
      check("sat_single", sat_flag, 0);

      // Two tiles back to back: 20 + (-15) = 5 in every lane.
      for (int r = 0; r < DEPTH; r++) tile_rows[r] = {4{32'd20}};
      send_tile(1'b1, 1'b0, 1'b0);
      for (int r = 0; r < DEPTH; r++) begin
         tile_rows[r] = {4{32'hFFFFFFF1}};
         exp_rows[r]  = {4{32'd5}};
      end
      push_expected();
      send_tile(1'b0, 1'b1, 1'b0);
      check_drain_start();
      wait_drain_done();
      check("sat_two_tile", sat_flag, 0);

      // Backpressure held at row 2 for three cycles.
      fill_ramp();
      push_expected();
      send_tile(1'b1, 1'b1, 1'b0);
      check_drain_start();
      wait_row(2);
      out_ready = 1'b0;
      repeat (3) begin
         tick();
         check("bp_out_row", out_row, 2);
         check("bp_out_valid", out_valid, 1);
         check("bp_in_ready", in_ready, 0);
         check("bp_out_data", out_data, exp_rows[2]);
      end
      out_ready = 1'b1;
      wait_drain_done();

      // Positive and negative saturation.
      fill_sat_tile(1);
      send_tile(1'b1, 1'b0, 1'b0);
      fill_sat_tile(2);
      push_expected();
      send_tile(1'b0, 1'b1, 1'b0);
      check_drain_start();
      check("sat_set", sat_flag, 1);
      wait_drain_done();
      check("sat_holds", sat_flag, 1);

      // Stalled input every other cycle gives the unstalled result.
      fill_ramp();
      push_expected();
      send_tile(1'b1, 1'b1, 1'b1);
      check_drain_start();
      check("sat_cleared_next_drain", sat_flag, 0);
      wait_drain_done();

      // Reset in the middle of a drain, then a fresh tile.
      fill_sat_tile(1);
      send_tile(1'b1, 1'b0, 1'b0);
      fill_sat_tile(2);
      push_expected();
      send_tile(1'b0, 1'b1, 1'b0);
      check("sat_before_reset", sat_flag, 1);
      wait_row(4);
      out_ready = 1'b0;
      rst = 1'b1;
      exp_q.delete();
      tick();
      rst = 1'b0;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_in_ready", in_ready, 1);
      check("mid_rst_sat_flag", sat_flag, 0);
      check("mid_rst_out_row", out_row, 0);
      out_ready = 1'b1;
      for (int r = 0; r < DEPTH; r++) begin
         tile_rows[r] = pack4(32'(1000*r), 32'(1000*r - 7), 32'(1000*r - 14), 32'(1000*r - 21));
         exp_rows[r]  = tile_rows[r];
      end
      push_expected();
      send_tile(1'b1, 1'b1, 1'b0);
      check_drain_start();
      wait_drain_done();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
